// File: rtl/ppu_vram_port.sv
// CPU-side PPU register port: decodes $2000/$2002/$2006/$2007, keeps the v/t/w address state
// and issues single-cycle VRAM strobes with auto-increment and a one-deep read buffer.
module ppu_vram_port #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned INC_BIG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_rw,
  input  logic [2:0]        cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic [7:0]        status_in,
  output logic              busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  output logic              vram_re,
  input  logic [7:0]        vram_rdata
);

  typedef enum logic [1:0] {StIdle, StWrIssue, StRdIssue, StRdCapture} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] v_q, v_d;
  logic [ADDR_W-1:0] t_q, t_d;
  logic [ADDR_W-1:0] inc;
  logic              w_q, w_d;
  logic              inc32_q, inc32_d;
  logic [7:0]        rbuf_q, rbuf_d;
  logic [7:0]        wbuf_q, wbuf_d;
  logic [7:0]        dout_q, dout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      v_q     <= '0;
      t_q     <= '0;
      w_q     <= 1'b0;
      inc32_q <= 1'b0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      t_q     <= t_d;
      w_q     <= w_d;
      inc32_q <= inc32_d;
      rbuf_q  <= rbuf_d;
      wbuf_q  <= wbuf_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    t_d     = t_q;
    w_d     = w_q;
    inc32_d = inc32_q;
    rbuf_d  = rbuf_q;
    wbuf_d  = wbuf_q;
    dout_d  = dout_q;
    inc     = inc32_q ? ADDR_W'(INC_BIG) : ADDR_W'(1);

    unique case (state_q)
      StIdle: begin
        // Strobes arriving in any other state are dropped.
        if (cpu_cs) begin
          if (cpu_rw) begin
            case (cpu_addr)
              3'd2: begin
                dout_d = status_in;
                w_d    = 1'b0;
              end
              3'd7: begin
                dout_d  = rbuf_q;
                state_d = StRdIssue;
              end
              default: ;
            endcase
          end else begin
            case (cpu_addr)
              3'd0: inc32_d = cpu_din[2];
              3'd6: begin
                if (!w_q) begin
                  t_d[ADDR_W-1:8] = cpu_din[ADDR_W-9:0];
                  w_d             = 1'b1;
                end else begin
                  t_d[7:0] = cpu_din;
                  v_d      = {t_q[ADDR_W-1:8], cpu_din};
                  w_d      = 1'b0;
                end
              end
              3'd7: begin
                wbuf_d  = cpu_din;
                state_d = StWrIssue;
              end
              default: ;
            endcase
          end
        end
      end
      StWrIssue: begin
        v_d     = v_q + inc;
        state_d = StIdle;
      end
      StRdIssue: state_d = StRdCapture;
      StRdCapture: begin
        rbuf_d  = vram_rdata;
        v_d     = v_q + inc;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_dout   = dout_q;
  assign busy       = (state_q != StIdle);
  assign vram_addr  = v_q;
  assign vram_we    = (state_q == StWrIssue);
  assign vram_wdata = wbuf_q;
  assign vram_re    = (state_q == StRdIssue);

endmodule
